// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory port: width codes, read-owner tag,
// and the command bundle that the arbiter places on the memory port.
package mem_pkg;

  localparam logic [2:0] W_BYTE         = 3'b000;
  localparam logic [2:0] W_HALF         = 3'b001;
  localparam logic [2:0] W_WORD         = 3'b010;
  localparam int         W_UNSIGNED_BIT = 2;

  // Which requester the read data arriving next cycle belongs to
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_IF   = 2'd1,
    RD_LS   = 2'd2
  } rd_owner_e;

  // Memory command without data payload (data width is a module parameter)
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  width;
    logic        we;
  } mem_cmd_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating counter of consecutive LS wins while IF waits. Clear beats increment.
module starve_counter #(
  parameter int MAX = 4,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          sat
);

  assign sat = (cnt == CW'(MAX));

  // Count up to MAX and stick there until cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (inc && !sat) cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported synchronous-read data memory between IF and LS.
// LS wins ties unless IF has been passed over STARVE_MAX times in a row.
// A one-deep owner tag steers the read data returning one cycle later.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          if_req_valid,
  input  logic [31:0]   if_req_addr,
  output logic          if_req_ready,
  output logic          if_rsp_valid,
  output logic [DW-1:0] if_rsp_data,
  input  logic          ls_req_valid,
  input  logic          ls_req_we,
  input  logic [2:0]    ls_req_width,
  input  logic [31:0]   ls_req_addr,
  input  logic [DW-1:0] ls_req_wdata,
  output logic          ls_req_ready,
  output logic          ls_rsp_valid,
  output logic [DW-1:0] ls_rsp_data,
  output logic [31:0]   mem_addr,
  output logic [2:0]    mem_width,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic          gnt_if, gnt_ls;
  logic          starve_sat;
  logic [CW-1:0] starve_cnt;
  rd_owner_e     rd_owner, rd_owner_nxt;
  logic          st_done;
  mem_cmd_t      cmd;

  // Reset gates the grant so nothing reaches memory while i_rst_n is low
  assign gnt_ls = i_rst_n && ls_req_valid && (!if_req_valid || !starve_sat);
  assign gnt_if = i_rst_n && if_req_valid && !gnt_ls;

  assign if_req_ready = gnt_if;
  assign ls_req_ready = gnt_ls;

  starve_counter #(.MAX(STARVE_MAX), .CW(CW)) u_starve (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc   (gnt_ls && if_req_valid),
    .clr   (gnt_if || !if_req_valid),
    .cnt   (starve_cnt),
    .sat   (starve_sat)
  );

  // Mux the winner onto the memory port; idle port reads as a benign word read of 0
  always_comb begin
    cmd       = '{addr: 32'h0, width: W_WORD, we: 1'b0};
    mem_wdata = '0;
    if (gnt_ls) begin
      cmd       = '{addr: ls_req_addr, width: ls_req_width, we: ls_req_we};
      mem_wdata = ls_req_wdata;
    end else if (gnt_if) begin
      cmd       = '{addr: if_req_addr, width: W_WORD, we: 1'b0};
    end
  end

  assign mem_addr  = cmd.addr;
  assign mem_width = cmd.width;
  assign mem_we    = cmd.we;

  // Tag the read issued this cycle so its data is routed back next cycle
  always_comb begin
    rd_owner_nxt = RD_NONE;
    if (gnt_if)                  rd_owner_nxt = RD_IF;
    else if (gnt_ls && !ls_req_we) rd_owner_nxt = RD_LS;
  end

  // Owner tag and store-completion flag; reset drops anything in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_owner <= RD_NONE;
      st_done  <= 1'b0;
    end else begin
      rd_owner <= rd_owner_nxt;
      st_done  <= gnt_ls && ls_req_we;
    end
  end

  // Data is forced to zero whenever the matching valid is low
  assign if_rsp_valid = (rd_owner == RD_IF);
  assign if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
  assign ls_rsp_valid = (rd_owner == RD_LS) || st_done;
  assign ls_rsp_data  = (rd_owner == RD_LS) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: stimulus pushes hand-computed responses into per-port
// queues, a negedge monitor pops and compares whenever a response appears.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int DW = 32;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          if_req_valid = 1'b0;
  logic [31:0]   if_req_addr = '0;
  logic          if_req_ready, if_rsp_valid;
  logic [DW-1:0] if_rsp_data;
  logic          ls_req_valid = 1'b0;
  logic          ls_req_we = 1'b0;
  logic [2:0]    ls_req_width = W_WORD;
  logic [31:0]   ls_req_addr = '0;
  logic [DW-1:0] ls_req_wdata = '0;
  logic          ls_req_ready, ls_rsp_valid;
  logic [DW-1:0] ls_rsp_data;
  logic [31:0]   mem_addr;
  logic [2:0]    mem_width;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int tests = 0;
  int fails = 0;
  logic [31:0] if_q[$];
  logic [31:0] ls_q[$];

  mem_arbiter #(.DW(DW), .STARVE_MAX(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_we(ls_req_we), .ls_req_width(ls_req_width),
    .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata), .ls_req_ready(ls_req_ready),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_addr(mem_addr), .mem_width(mem_width), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  // Memory model: word-addressed, synchronous read, extension done by memory
  logic [31:0] mem [0:255];
  logic        loaded = 1'b0;

  function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [2:0] wd);
    if (wd[1]) return w;
    if (wd[0]) return wd[W_UNSIGNED_BIT] ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
    return wd[W_UNSIGNED_BIT] ? {24'h0, w[7:0]} : {{24{w[7]}}, w[7:0]};
  endfunction

  always @(posedge i_clk) begin
    if (!loaded) begin
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h30] <= 32'h0000_80F0;
      loaded     <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
    mem_rdata <= ld_ext(mem[mem_addr[7:0]], mem_width);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every presented response must match the oldest expected one
  always @(negedge i_clk) begin
    if (if_rsp_valid) begin
      if (if_q.size() == 0) chk("if_rsp_unexpected", 32'(if_rsp_valid), 32'd0);
      else                  chk("if_rsp_data", if_rsp_data, if_q.pop_front());
    end else begin
      chk("if_rsp_data_idle", if_rsp_data, 32'd0);
    end
    if (ls_rsp_valid) begin
      if (ls_q.size() == 0) chk("ls_rsp_unexpected", 32'(ls_rsp_valid), 32'd0);
      else                  chk("ls_rsp_data", ls_rsp_data, ls_q.pop_front());
    end else begin
      chk("ls_rsp_data_idle", ls_rsp_data, 32'd0);
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_if_req_ready"}, 32'(if_req_ready), 32'd0);
    chk({tag, "_ls_req_ready"}, 32'(ls_req_ready), 32'd0);
    chk({tag, "_if_rsp_valid"}, 32'(if_rsp_valid), 32'd0);
    chk({tag, "_ls_rsp_valid"}, 32'(ls_rsp_valid), 32'd0);
    chk({tag, "_if_rsp_data"},  if_rsp_data, 32'd0);
    chk({tag, "_ls_rsp_data"},  ls_rsp_data, 32'd0);
    chk({tag, "_mem_we"},       32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"},     mem_addr, 32'd0);
    chk({tag, "_mem_wdata"},    mem_wdata, 32'd0);
    chk({tag, "_mem_width"},    32'(mem_width), 32'(W_WORD));
  endtask

  // One cycle of stimulus: drive, check grant, queue the expected response
  task automatic drive(input logic iv, input logic [31:0] ia,
                       input logic lv, input logic we, input logic [2:0] w,
                       input logic [31:0] la, input logic [31:0] wd,
                       input logic e_if, input logic e_ls, input logic [31:0] e_data);
    @(negedge i_clk);
    if_req_valid = iv; if_req_addr = ia;
    ls_req_valid = lv; ls_req_we = we; ls_req_width = w;
    ls_req_addr = la;  ls_req_wdata = wd;
    #1;
    chk("if_req_ready", 32'(if_req_ready), 32'(e_if));
    chk("ls_req_ready", 32'(ls_req_ready), 32'(e_ls));
    if (e_if) begin
      chk("if_mem_width", 32'(mem_width), 32'(W_WORD));
      chk("if_mem_addr", mem_addr, ia);
      if_q.push_back(e_data);
    end
    if (e_ls) begin
      chk("ls_mem_we", 32'(mem_we), 32'(we));
      ls_q.push_back(e_data);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, W_WORD, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    #1 chk_reset_outputs("rst");
    i_rst_n = 1'b1;

    // IF only, three back-to-back reads
    for (int k = 0; k < 3; k++) drive(1, 32'h10, 0, 0, W_WORD, 0, 0, 1, 0, 32'hDEADBEEF);
    idle(1);

    // Store then load of the same word
    drive(0, 0, 1, 1, W_WORD, 32'h20, 32'h12345678, 0, 1, 32'h0);
    drive(0, 0, 1, 0, W_WORD, 32'h20, 32'h0,        0, 1, 32'h12345678);
    idle(1);

    // Narrow loads from word 0x30 = 0x000080F0
    drive(0, 0, 1, 0, W_HALF, 32'h30, 0, 0, 1, 32'hFFFF80F0);
    drive(0, 0, 1, 0, 3'b101, 32'h30, 0, 0, 1, 32'h000080F0);
    drive(0, 0, 1, 0, W_BYTE, 32'h30, 0, 0, 1, 32'hFFFFFFF0);
    idle(1);

    // Both requesting: LS x4 then IF, twice
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) drive(1, 32'h10, 1, 0, W_WORD, 32'h30, 0, 1, 0, 32'hDEADBEEF);
      else                  drive(1, 32'h10, 1, 0, W_WORD, 32'h30, 0, 0, 1, 32'h000080F0);
    end
    idle(1);

    // Reset arrives while an IF read is granted; its response must never show
    @(negedge i_clk);
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    #1 chk("mid_if_req_ready", 32'(if_req_ready), 32'd1);
    #1 i_rst_n = 1'b0;
    #1 chk_reset_outputs("mid");
    @(negedge i_clk);
    if_req_valid = 1'b0; if_req_addr = '0;
    repeat (2) @(negedge i_clk);
    #1 chk_reset_outputs("hold");

    // First cycle out of reset grants immediately
    @(negedge i_clk);
    i_rst_n = 1'b1; if_req_valid = 1'b1; if_req_addr = 32'h10;
    #1 chk("post_rst_if_req_ready", 32'(if_req_ready), 32'd1);
    if_q.push_back(32'hDEADBEEF);
    idle(3);

    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("ls_q_drained", 32'(ls_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
